sample_sdiv_11ns_6nu: RTL and testbench

Sequential signed-by-unsigned divider for the sample datapath. It is the inverse operator of the existing 6-bit-unsigned × 11-bit-signed multiplier. It divides an 11-bit signed dividend by a 6-bit unsigned divisor and returns a truncated-toward-zero quotient plus a remainder. It is iterative (one quotient bit per cycle) and uses a start/done handshake. It is gated by the same `ce` clock-enable used by the other arithmetic cores.

---
 rtl/sample_sdiv_11ns_6nu.sv | 134 +++++++++++++
 tb/tb_sample_sdiv_11ns_6nu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_sdiv_11ns_6nu.sv
// Iterative restoring divider: signed 11-bit dividend / unsigned 6-bit divisor.
// Latency: done 12 ce-qualified cycles after start is accepted; one quotient bit per cycle.
// Backpressure: none; start is ignored while busy, ce=0 freezes all state and outputs.
module sample_sdiv_11ns_6nu #(
   parameter logic [31:0] ID         = 32'd1,
   parameter logic [31:0] din0_WIDTH = 32'd11,
   parameter logic [31:0] din1_WIDTH = 32'd6,
   parameter logic [31:0] dout_WIDTH = 32'd11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH:0]   remd
);

   localparam int W0 = int'(din0_WIDTH);
   localparam int W1 = int'(din1_WIDTH);
   localparam int CW = $clog2(W0);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   // Instance identifier has no functional effect.
   logic unused_id;
   assign unused_id = ^ID;

   state_t          state_q, state_d;
   logic            sign_q, sign_d;
   // Dividend magnitude, shifted out MSB first while quotient bits shift in at the LSB.
   // Held unsigned, so |-1024| = 1024 still fits in W0 bits.
   logic [W0-1:0]   a_q, a_d;
   logic [W1-1:0]   div_q, div_d;
   logic [W1-1:0]   rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W0-1:0]   dout_q, dout_d;
   logic [W1:0]     remd_q, remd_d;

   logic [W1:0]     pr;
   logic            ge;

   // Partial remainder with the next dividend bit shifted in, and the trial-subtract decision.
   assign pr = {rem_q, a_q[W0-1]};
   assign ge = (pr >= {1'b0, div_q});

   // State register; ce=0 holds everything, reset overrides ce.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         a_q     <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         remd_q  <= '0;
      end else if (ce) begin
         state_q <= state_d;
         sign_q  <= sign_d;
         a_q     <= a_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         remd_q  <= remd_d;
      end
   end

   // Next-state logic: capture, restoring iterations, then sign fix-up / divide-by-zero override.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      a_d     = a_q;
      div_d   = div_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      remd_d  = remd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d  = din0[W0-1];
               a_d     = din0[W0-1] ? (~din0 + 1'b1) : din0;
               div_d   = din1;
               rem_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = ge ? W1'(pr - {1'b0, div_q}) : pr[W1-1:0];
            a_d   = {a_q[W0-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W0 - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (div_q == '0) begin
               // Saturate toward the dividend's sign; remainder is meaningless so report 0.
               dout_d = sign_q ? {1'b1, {(W0-1){1'b0}}} : {1'b0, {(W0-1){1'b1}}};
               remd_d = '0;
            end else begin
               // Truncation toward zero: both quotient and remainder take the dividend's sign.
               dout_d = sign_q ? -a_q : a_q;
               remd_d = sign_q ? -{1'b0, rem_q} : {1'b0, rem_q};
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
   assign remd = remd_q;

endmodule

// File: tb/tb_sample_sdiv_11ns_6nu.sv
// Bench for sample_sdiv_11ns_6nu: directed operations checked against an arithmetic reference.
// Reference result comes from integer / and %, timing from a ce-qualified edge count.
// Outputs are compared every cycle at the falling edge; inputs change 1 time unit after the rising edge.
module tb_sample_sdiv_11ns_6nu;

   logic        clk = 1'b0;
   logic        reset, ce, start;
   logic [10:0] din0;
   logic [5:0]  din1;
   logic        busy, done;
   logic [10:0] dout;
   logic [6:0]  remd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sample_sdiv_11ns_6nu dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .start (start),
      .din0  (din0),
      .din1  (din1),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .remd  (remd)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: C-style truncating division, divide-by-zero saturates.
   function automatic void ref_div(input logic [10:0] a, input logic [5:0] b,
                                   output logic [10:0] q, output logic [6:0] r);
      int sa, sb;
      sa = $signed(a);
      sb = int'(b);
      if (sb == 0) begin
         q = (sa < 0) ? 11'h400 : 11'h3FF;
         r = 7'd0;
      end else begin
         q = 11'(sa / sb);
         r = 7'(sa % sb);
      end
   endfunction

   // Model: an accepted operation completes on its 12th ce-qualified edge.
   bit          m_active = 1'b0;
   int          m_cnt    = 0;
   logic        m_done   = 1'b0;
   logic [10:0] m_dout   = '0, p_dout = '0;
   logic [6:0]  m_remd   = '0, p_remd = '0;
   bit          chk_en   = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_active = 1'b0;
         m_cnt    = 0;
         m_done   = 1'b0;
         m_dout   = '0;
         m_remd   = '0;
      end else if (ce) begin
         m_done = 1'b0;
         if (m_active) begin
            m_cnt++;
            if (m_cnt == 12) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_dout   = p_dout;
               m_remd   = p_remd;
            end
         end else if (start) begin
            m_active = 1'b1;
            m_cnt    = 0;
            ref_div(din0, din1, p_dout, p_remd);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'b0, busy}, {31'b0, m_active});
         check("done", {31'b0, done}, {31'b0, m_done});
         check("dout", {21'b0, dout}, {21'b0, m_dout});
         check("remd", {25'b0, remd}, {25'b0, m_remd});
      end
   end

   // Issue one operation from the current cycle and wait (bounded) for done.
   task automatic run_op(input string nm, input logic [10:0] a, input logic [5:0] b,
                         input logic [10:0] eq, input logic [6:0] er,
                         input int elat, input int ebusy);
      int lat, bcnt;
      din0  = a;
      din1  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      din0  = 11'($urandom);
      din1  = 6'($urandom);
      lat   = 0;
      bcnt  = 0;
      while (!done && lat < 60) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({nm, "_lat"},  lat, elat);
      check({nm, "_busy"}, bcnt, ebusy);
      check({nm, "_q"},    {21'b0, dout}, {21'b0, eq});
      check({nm, "_r"},    {25'b0, remd}, {25'b0, er});
   endtask

   task automatic count_done(input string nm, input int n, input int exp);
      int c;
      c = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (done) c++;
      end
      check(nm, c, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_dout", {21'b0, dout}, 32'd0);
      check("rst_remd", {25'b0, remd}, 32'd0);

      // Back-to-back: each starts in the previous done cycle.
      run_op("p100_7",   11'd100,     6'd7,  11'd14,      7'd2,       12, 12);
      run_op("m100_7",   11'(-100),   6'd7,  11'(-14),    7'(-2),     12, 12);
      run_op("m1024_1",  11'h400,     6'd1,  11'h400,     7'd0,       12, 12);
      run_op("p1023_63", 11'd1023,    6'd63, 11'd16,      7'd15,      12, 12);
      run_op("p500_0",   11'd500,     6'd0,  11'h3FF,     7'd0,       12, 12);
      run_op("m5_0",     11'(-5),     6'd0,  11'h400,     7'd0,       12, 12);

      // ce low for 5 cycles in the middle of the iterations.
      fork
         run_op("stall", 11'd100, 6'd7, 11'd14, 7'd2, 17, 17);
         begin
            repeat (4) @(posedge clk);
            #1 ce = 1'b0;
            repeat (5) @(posedge clk);
            #1 ce = 1'b1;
         end
      join
      // done must hold while ce is low.
      ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("done_hold", {31'b0, done}, 32'd1);
      ce = 1'b1;
      @(posedge clk); #1;
      check("done_clear", {31'b0, done}, 32'd0);

      // start while busy is ignored.
      fork
         run_op("busy_ign", 11'd100, 6'd7, 11'd14, 7'd2, 12, 12);
         begin
            repeat (4) @(posedge clk);
            #1 din0 = 11'd50; din1 = 6'd3; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      join
      count_done("single_done", 20, 0);

      // Reset in the middle of an operation aborts it.
      din0 = 11'd100; din1 = 6'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_dout", {21'b0, dout}, 32'd0);
      check("abort_remd", {25'b0, remd}, 32'd0);
      count_done("abort_nodone", 20, 0);

      // Reset and start together: reset wins.
      reset = 1'b1; start = 1'b1; din0 = 11'd9; din1 = 6'd4;
      @(posedge clk); #1 reset = 1'b0; start = 1'b0;
      check("rst_start_busy", {31'b0, busy}, 32'd0);
      count_done("rst_start_nodone", 15, 0);

      run_op("p9_4", 11'd9, 6'd4, 11'd2, 7'd1, 12, 12);
      @(posedge clk); #1;

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
